mem_sum_master: RTL and testbench

Bus initiator for the single-cycle CPU's word-addressed data memory port: it drives the memory's address, write-data and write-enable lines and consumes its combinational read data. On a start pulse it reads `count` consecutive words from `src_addr`, accumulates their 32-bit sum, and writes the sum to `dst_addr`. It sits beside the CPU as a second memory master, muxed onto the data memory port while `busy` is high, and is used for self-test and checksum offload.

---
 rtl/mem_sum_pkg.sv | 18 +
 rtl/mem_sum_addr_gen.sv | 66 ++++++
 rtl/mem_sum_master.sv | 135 +++++++++++++
 tb/tb_mem_sum_master.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_sum_pkg.sv
// rtl/mem_sum_pkg.sv - shared types and constants for the memory sum master
// Contents: FSM state enum, default widths, word stride.
package mem_sum_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int CNT_W      = 6;
  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_sum_addr_gen.sv
// rtl/mem_sum_addr_gen.sv - word index counter and data memory address mux
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             zero the index (job accepted)
//   advance           step the index by one word (read cycle)
//   sel_src, sel_dst  drive source-walk or destination address; else 0
//   src_addr          latched source byte address
//   dst_addr          latched destination byte address
//   count             latched word count
//   mem_a             address to the data memory
//   last              current index is the final word of the job
module mem_sum_addr_gen
  import mem_sum_pkg::*;
#(
  parameter int ADDR_W = mem_sum_pkg::ADDR_W,
  parameter int CNT_W  = mem_sum_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic              sel_src,
  input  logic              sel_dst,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_a,
  output logic              last
);

  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] src_walk;

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (advance) begin
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Only consulted while reading, where count is known to be non-zero.
  assign last = (idx_q == (count - CNT_W'(1)));

  // Byte offset added modulo 2^ADDR_W; low bits of the source pass through.
  assign src_walk = src_addr + (ADDR_W'(idx_q) << WORD_SHIFT);

  always_comb begin
    mem_a = '0;
    if (sel_src) begin
      mem_a = src_walk;
    end else if (sel_dst) begin
      mem_a = dst_addr;
    end
  end

endmodule

// File: rtl/mem_sum_master.sv
// rtl/mem_sum_master.sv - data memory initiator that sums a word range and writes the result
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 job request, sampled only in IDLE
//   src_addr, dst_addr    first source byte address, result byte address
//   count                 number of words to sum (0 writes 0)
//   mem_a, mem_din, mem_we  data memory address, write data, write enable
//   mem_dout              combinational read data from the data memory
//   busy                  high during READ and WRITE cycles
//   done                  one-cycle pulse after the result write
//   sum, ovf              registered result, sticky carry-out of the sum
module mem_sum_master
  import mem_sum_pkg::*;
#(
  parameter int DATA_W = mem_sum_pkg::DATA_W,
  parameter int ADDR_W = mem_sum_pkg::ADDR_W,
  parameter int CNT_W  = mem_sum_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic              accept;
  logic              last;
  logic [DATA_W:0]   acc_next;

  // One extra bit keeps the carry-out of each accumulation step.
  assign acc_next = {1'b0, acc_q} + {1'b0, mem_dout};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = count;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (count == '0) ? WRITE : READ;
        end
      end
      READ: begin
        acc_d = acc_next[DATA_W-1:0];
        ovf_d = ovf_q | acc_next[DATA_W];
        if (last) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        sum_d   = acc_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  mem_sum_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .advance  (state_q == READ),
    .sel_src  (state_q == READ),
    .sel_dst  (state_q == WRITE),
    .src_addr (src_q),
    .dst_addr (dst_q),
    .count    (cnt_q),
    .mem_a    (mem_a),
    .last     (last)
  );

  // Write data is forced to zero outside WRITE so the shared port stays quiet.
  assign mem_we  = (state_q == WRITE);
  assign mem_din = (state_q == WRITE) ? acc_q : '0;
  assign busy    = (state_q == READ) || (state_q == WRITE);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mem_sum_master.sv
// tb/tb_mem_sum_master.sv - scoreboard bench for mem_sum_master against a 32-word memory
module tb_mem_sum_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [5:0]  count = '0;
  logic [31:0] mem_a;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        ovf;

  always #5 clk = ~clk;

  mem_sum_master dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .mem_a    (mem_a),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .ovf      (ovf)
  );

  logic [31:0] mem [0:31];
  logic        pk_en = 1'b0;
  logic [4:0]  pk_idx = '0;
  logic [31:0] pk_val = '0;

  always @(posedge clk) begin
    if (pk_en) mem[pk_idx] <= pk_val;
    else if (mem_we) mem[mem_a[6:2]] <= mem_din;
  end
  assign mem_dout = mem[mem_a[6:2]];

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] din;
  } bus_t;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
  } res_t;

  bus_t exp_bus[$];
  res_t exp_res[$];

  int  n_chk = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Monitor: every busy cycle consumes one expected bus beat, every done one result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", mem_a, 32'hFFFF_FFFF);
        end else begin
          bus_t b;
          b = exp_bus.pop_front();
          check("bus_addr", mem_a, b.a);
          check("bus_we", {31'd0, mem_we}, {31'd0, b.we});
          if (b.we) check("bus_din", mem_din, b.din);
        end
      end else begin
        check("idle_we", {31'd0, mem_we}, 32'd0);
        check("idle_addr", mem_a, 32'd0);
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          check("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("res_sum", sum, r.sum);
          check("res_ovf", {31'd0, ovf}, {31'd0, r.ovf});
        end
      end
    end
  end

  task automatic poke(input logic [4:0] i, input logic [31:0] v);
    @(negedge clk);
    pk_en = 1'b1; pk_idx = i; pk_val = v;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_a"}, mem_a, 32'd0);
    check({tag, "_din"}, mem_din, 32'd0);
    check({tag, "_sum"}, sum, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  // Issues a job, queues its expected bus beats and result, checks done latency.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [5:0] n,
                         input logic [31:0] exp_sum, input logic exp_ovf, input bit inject);
    int lat;
    for (int i = 0; i < n; i++) exp_bus.push_back('{a: s + 32'(i) * 4, we: 1'b0, din: 32'd0});
    exp_bus.push_back('{a: d, we: 1'b1, din: exp_sum});
    exp_res.push_back('{sum: exp_sum, ovf: exp_ovf});
    @(negedge clk);
    src_addr = s; dst_addr = d; count = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (inject && lat == 1) begin
        src_addr = 32'h0; dst_addr = 32'h6C; count = 6'd1; start = 1'b1;
      end
      if (inject && lat == 2) start = 1'b0;
      if (done || lat > 80) break;
    end
    check("done_latency", 32'(lat), 32'(n) + 32'd2);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    mon_en = 1'b1;

    poke(5'h14, 32'h0000_00a3);
    poke(5'h15, 32'h0000_0027);
    poke(5'h16, 32'h0000_0079);
    poke(5'h17, 32'h0000_0115);
    poke(5'h18, 32'h0);
    run_job(32'h50, 32'h60, 6'd4, 32'h258, 1'b0, 1'b0);
    check("mem_w18", mem[5'h18], 32'h258);

    poke(5'h10, 32'hDEAD_BEEF);
    run_job(32'h0, 32'h40, 6'd0, 32'h0, 1'b0, 1'b0);
    check("mem_w10", mem[5'h10], 32'h0);

    poke(5'h00, 32'hFFFF_FFFF);
    poke(5'h01, 32'h0000_0002);
    run_job(32'h0, 32'h08, 6'd2, 32'h1, 1'b1, 1'b0);
    check("mem_w02", mem[5'h02], 32'h1);
    run_job(32'h50, 32'h64, 6'd4, 32'h258, 1'b0, 1'b0);

    poke(5'h1F, 32'h0000_1000);
    run_job(32'h7C, 32'h20, 6'd2, 32'h0000_0FFF, 1'b1, 1'b0);
    check("mem_w08", mem[5'h08], 32'h0000_0FFF);

    poke(5'h1A, 32'h0);
    poke(5'h1B, 32'h0);
    run_job(32'h50, 32'h68, 6'd4, 32'h258, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("mem_w1a", mem[5'h1A], 32'h258);
    check("mem_w1b_untouched", mem[5'h1B], 32'h0);

    poke(5'h1C, 32'h5A5A_5A5A);
    exp_bus.push_back('{a: 32'h50, we: 1'b0, din: 32'd0});
    exp_bus.push_back('{a: 32'h54, we: 1'b0, din: 32'd0});
    @(negedge clk);
    src_addr = 32'h50; dst_addr = 32'h70; count = 6'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (8) @(negedge clk);
    check("mem_w1c_untouched", mem[5'h1C], 32'h5A5A_5A5A);
    check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
